// File: rtl/mem_viewer.sv
// Memory debug viewer: button-stepped address to the memory debug port, returned word shown on 8 hex digits.
// Optional build macro MEMVIEW_DEBOUNCE_EN adds a stable-level filter on each button.
module mem_viewer #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ADDR_W-1:0] led,
    output logic [7:0]        an,
    output logic [7:0]        seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 2 || DEBOUNCE_CYC < 2 || DATA_W != 32) begin : g_bad_param
        $error("mem_viewer: SCAN_DIV and DEBOUNCE_CYC must be >= 2, DATA_W must be 32");
    end

    // Button conditioning; bit 0 is inc, bit 1 is dec.
    logic [1:0] btn_raw;
    logic [1:0] btn_s1;
    logic [1:0] btn_s2;
    logic [1:0] btn_lvl;
    logic [1:0] btn_q;
    logic [1:0] btn_pulse;

    assign btn_raw = {dec, inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_q  <= '0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
            btn_q  <= btn_lvl;
        end
    end

`ifdef MEMVIEW_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC);

    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      db_lvl;

    // Level flips only after sync2 has disagreed with it for DEBOUNCE_CYC consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_lvl <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_lvl[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_lvl = db_lvl;
`else
    assign btn_lvl = btn_s2;
`endif

    assign btn_pulse = btn_lvl & ~btn_q;

    // Address step; simultaneous inc and dec cancel.
    logic [ADDR_W-1:0] addr_nxt;

    always_comb begin
        addr_nxt = addr_out;
        case (btn_pulse)
            2'b01:   addr_nxt = addr_out + ADDR_W'(1);
            2'b10:   addr_nxt = addr_out - ADDR_W'(1);
            default: addr_nxt = addr_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_out <= '0;
            led      <= '0;
        end else begin
            addr_out <= addr_nxt;
            led      <= addr_nxt;
        end
    end

    // Word capture and digit scan.
    logic [DATA_W-1:0] data_q;
    logic [DIV_W-1:0]  div_q;
    logic [2:0]        digit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            div_q   <= '0;
            digit_q <= '0;
        end else begin
            data_q <= mem_data;
            if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                div_q   <= '0;
                digit_q <= digit_q + 3'd1;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [3:0] nib;

    assign nib = data_q[{digit_q, 2'b00} +: 4];

    // Display outputs decode registered state only.
    always_comb begin
        an          = 8'hFF;
        an[digit_q] = 1'b0;
        seg         = hex_seg(nib);
    end

endmodule

// File: tb/tb_mem_viewer.sv
// Scoreboard bench for mem_viewer: reset, stepping, wrap, simultaneous presses, digit scan,
// and bounce rejection when MEMVIEW_DEBOUNCE_EN is defined.
module tb_mem_viewer;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CYC = 8;
`ifdef MEMVIEW_DEBOUNCE_EN
    localparam int unsigned LAT  = DEBOUNCE_CYC + 2;
    localparam int unsigned HOLD = DEBOUNCE_CYC + 4;
`else
    localparam int unsigned LAT  = 2;
    localparam int unsigned HOLD = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inc;
    logic        dec;
    logic [31:0] mem_data;
    logic [7:0]  addr_out;
    logic [7:0]  led;
    logic [7:0]  an;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  addr_q [$];
    logic [15:0] disp_q [$];

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clk = ~clk;

    mem_viewer #(
        .ADDR_W       (8),
        .DATA_W       (32),
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc),
        .dec      (dec),
        .mem_data (mem_data),
        .addr_out (addr_out),
        .led      (led),
        .an       (an),
        .seg      (seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_addr(input string tag);
        logic [7:0] e;
        e = addr_q.pop_front();
        check({tag, "_addr"}, 32'(addr_out), 32'(e));
        check({tag, "_led"}, 32'(led), 32'(e));
    endtask

    task automatic pop_disp(input string tag);
        logic [15:0] e;
        e = disp_q.pop_front();
        check({tag, "_an"}, 32'(an), 32'(e[15:8]));
        check({tag, "_seg"}, 32'(seg), 32'(e[7:0]));
    endtask

    task automatic cycle_addr(input string tag, input logic [7:0] e);
        addr_q.push_back(e);
        tick();
        pop_addr(tag);
    endtask

    // Hold the buttons for HOLD cycles, release, then let everything settle.
    task automatic press(input logic do_inc, input logic do_dec, input logic [7:0] from,
                         input logic [7:0] to, input string tag);
        inc = do_inc;
        dec = do_dec;
        for (int k = 1; k <= int'(HOLD); k++)
            cycle_addr(tag, (k >= int'(LAT) + 1) ? to : from);
        inc = 1'b0;
        dec = 1'b0;
        for (int k = 0; k < int'(HOLD); k++)
            cycle_addr({tag, "_rel"}, to);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        inc      = 1'b1;
        dec      = 1'b0;
        mem_data = 32'hDEADBEEF;

        // Reset held with a button pressed.
        for (int i = 0; i < 3; i++) begin
            addr_q.push_back(8'h00);
            disp_q.push_back({8'hFE, 8'hC0});
            tick();
            pop_addr("reset");
            pop_disp("reset");
        end

        // Edge 1 after release is the first edge sampling inc high; low nibble F shows 8E.
        rst = 1'b0;
        disp_q.push_back({8'hFE, 8'h8E});
        for (int k = 1; k <= 20; k++) begin
            addr_q.push_back((k >= int'(LAT) + 1) ? 8'h01 : 8'h00);
            tick();
            pop_addr("step");
            if (k == 1) pop_disp("capture");
        end
        inc = 1'b0;
        for (int k = 0; k < int'(HOLD); k++) cycle_addr("step_rel", 8'h01);

        press(1'b0, 1'b1, 8'h01, 8'h00, "dec1");
        press(1'b0, 1'b1, 8'h00, 8'hFF, "wrap_dn");
        press(1'b1, 1'b0, 8'hFF, 8'h00, "wrap_up");
        press(1'b1, 1'b1, 8'h00, 8'h00, "both");
        press(1'b1, 1'b0, 8'h00, 8'h01, "inc2");
        press(1'b1, 1'b1, 8'h01, 8'h01, "both2");

`ifdef MEMVIEW_DEBOUNCE_EN
        // Short bounces must not step; the final sustained rise steps once.
        for (int p = 0; p < 5; p++) begin
            inc = 1'b1;
            for (int k = 0; k < 3; k++) cycle_addr("bounce", 8'h01);
            inc = 1'b0;
            for (int k = 0; k < 3; k++) cycle_addr("bounce", 8'h01);
        end
        inc = 1'b1;
        for (int k = 1; k <= int'(LAT) + 6; k++)
            cycle_addr("bounce_step", (k >= int'(LAT) + 1) ? 8'h02 : 8'h01);
        inc = 1'b0;
        for (int k = 0; k < int'(HOLD); k++) cycle_addr("bounce_rel", 8'h02);
`endif

        // Digit scan from a fresh reset.
        rst      = 1'b1;
        mem_data = 32'h12345678;
        addr_q.push_back(8'h00);
        disp_q.push_back({8'hFE, 8'hC0});
        tick();
        pop_addr("scan_rst");
        pop_disp("scan_rst");
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            int         digit;
            logic [7:0] an_e;
            logic [3:0] nib_e;
            logic [31:0] word;
            word  = 32'h12345678;
            digit = (k / int'(SCAN_DIV)) % 8;
            an_e  = ~(8'h01 << digit);
            nib_e = 4'(word >> (4 * digit));
            disp_q.push_back({an_e, seg_tab[nib_e]});
            tick();
            pop_disp("scan");
        end

        check("sb_drain", 32'(addr_q.size() + disp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
